// File: rtl/mesh_noc_fabric_if.sv
// Terminal-side bundle for mesh_noc_fabric: source FIFO pull side and output FIFO sink side.
// Handshake: popin[i] high at a rising edge transfers data_out_i_in slice i; pop[i] with pndng[i] removes data_out slice i.
interface mesh_noc_fabric_if #(
  parameter int N = 16,
  parameter int W = 32
);
  logic [N*W-1:0] data_out_i_in;
  logic [N-1:0]   pndng_i_in;
  logic [N-1:0]   popin;
  logic [N*W-1:0] data_out;
  logic [N-1:0]   pndng;
  logic [N-1:0]   pop;

  modport master (
    output data_out_i_in, pndng_i_in, pop,
    input  popin, data_out, pndng
  );

  modport slave (
    input  data_out_i_in, pndng_i_in, pop,
    output popin, data_out, pndng
  );
endinterface

// File: rtl/mesh_noc_fabric.sv
// Behavioural mesh NoC fabric: per-terminal input/output FIFOs joined by a one-packet-per-cycle round-robin switch.
// Optional broadcast on nxt_jump == bdcst is compiled in with `define MESH_BCAST_EN.
module mesh_noc_fabric #(
  parameter int          ROWS       = 4,
  parameter int          COLUMS     = 4,
  parameter int          pckg_sz    = 32,
  parameter int          fifo_depth = 16,
  parameter logic [7:0]  bdcst      = 8'hFF
) (
  input logic              clk,
  input logic              reset,
  mesh_noc_fabric_if.slave bus
);
  localparam int N  = 2 * (ROWS + COLUMS);
  localparam int AW = $clog2(fifo_depth);
  localparam int PW = $clog2(N);

  logic [pckg_sz-1:0] r_in_mem  [N][fifo_depth];
  logic [pckg_sz-1:0] r_out_mem [N][fifo_depth];
  logic [AW:0]        r_in_wr   [N];
  logic [AW:0]        r_in_rd   [N];
  logic [AW:0]        r_out_wr  [N];
  logic [AW:0]        r_out_rd  [N];
  logic [PW-1:0]      r_last;

  logic [N-1:0]       w_in_empty, w_in_full, w_out_empty, w_out_full;
  logic [N-1:0]       w_out_space, w_out_pop, w_popin, w_ready, w_push;
  logic [pckg_sz-1:0] w_in_head [N];
  logic [N-1:0]       w_dest    [N];
  logic               w_gnt_vld;
  logic [PW-1:0]      w_gnt_idx;
  logic [PW-1:0]      w_idx;
  logic [pckg_sz-1:0] w_gnt_pkt;

  // Map a {row,col} address to a one-hot terminal mask; corners and off-mesh addresses give 0.
  function automatic logic [N-1:0] uni_mask(input logic [3:0] row, input logic [3:0] col);
    int r, c;
    logic [N-1:0] m;
    r = int'(row);
    c = int'(col);
    m = '0;
    if (r == 0 && c >= 1 && c <= COLUMS)               m[c-1] = 1'b1;
    else if (c == 0 && r >= 1 && r <= ROWS)            m[COLUMS+r-1] = 1'b1;
    else if (r == ROWS+1 && c >= 1 && c <= COLUMS)     m[COLUMS+ROWS+c-1] = 1'b1;
    else if (c == COLUMS+1 && r >= 1 && r <= ROWS)     m[2*COLUMS+ROWS+r-1] = 1'b1;
    return m;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_in_empty[i]  = (r_in_wr[i] == r_in_rd[i]);
      w_in_full[i]   = (r_in_wr[i][AW] != r_in_rd[i][AW]) &&
                       (r_in_wr[i][AW-1:0] == r_in_rd[i][AW-1:0]);
      w_out_empty[i] = (r_out_wr[i] == r_out_rd[i]);
      w_out_full[i]  = (r_out_wr[i][AW] != r_out_rd[i][AW]) &&
                       (r_out_wr[i][AW-1:0] == r_out_rd[i][AW-1:0]);
      w_in_head[i]   = r_in_mem[i][r_in_rd[i][AW-1:0]];
    end
  end

  // A full output FIFO still takes a push when its head leaves in the same cycle.
  always_comb begin
    w_out_pop   = bus.pop & ~w_out_empty;
    w_out_space = ~w_out_full | bus.pop;
    w_popin     = bus.pndng_i_in & ~w_in_full & {N{~reset}};
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_dest[i] = uni_mask(w_in_head[i][pckg_sz-9 -: 4], w_in_head[i][pckg_sz-13 -: 4]);
`ifdef MESH_BCAST_EN
      if (w_in_head[i][pckg_sz-1 -: 8] == bdcst) w_dest[i] = ~(N'(1) << i);
`endif
      w_ready[i] = ~w_in_empty[i] & ~|(w_dest[i] & ~w_out_space);
    end
  end

  // Round-robin scan starts one past the last granted input.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = PW'((int'(r_last) + k) % N);
      if (!w_gnt_vld && w_ready[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    w_gnt_pkt = w_in_head[w_gnt_idx];
    w_push    = w_gnt_vld ? w_dest[w_gnt_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= '0;
      for (int i = 0; i < N; i++) begin
        r_in_wr[i]  <= '0;
        r_in_rd[i]  <= '0;
        r_out_wr[i] <= '0;
        r_out_rd[i] <= '0;
      end
    end else begin
      if (w_gnt_vld) r_last <= w_gnt_idx;
      for (int i = 0; i < N; i++) begin
        if (w_popin[i])                             r_in_wr[i]  <= r_in_wr[i] + 1'b1;
        if (w_gnt_vld && (w_gnt_idx == PW'(i)))     r_in_rd[i]  <= r_in_rd[i] + 1'b1;
        if (w_push[i])                              r_out_wr[i] <= r_out_wr[i] + 1'b1;
        if (w_out_pop[i])                           r_out_rd[i] <= r_out_rd[i] + 1'b1;
      end
    end
  end

  // Storage carries no reset; the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_popin[i]) r_in_mem[i][r_in_wr[i][AW-1:0]]  <= bus.data_out_i_in[i*pckg_sz +: pckg_sz];
      if (w_push[i])  r_out_mem[i][r_out_wr[i][AW-1:0]] <= w_gnt_pkt;
    end
  end

  always_comb begin
    bus.popin = w_popin;
    bus.pndng = ~w_out_empty & {N{~reset}};
    for (int j = 0; j < N; j++) begin
      bus.data_out[j*pckg_sz +: pckg_sz] = (w_out_empty[j] || reset) ? '0
                                         : r_out_mem[j][r_out_rd[j][AW-1:0]];
    end
  end
endmodule

// File: tb/tb_mesh_noc_fabric.sv
// Bench for mesh_noc_fabric: directed scenarios plus random traffic against a queue-based terminal model.
module tb_mesh_noc_fabric;
  localparam int ROWS   = 4;
  localparam int COLUMS = 4;
  localparam int W      = 32;
  localparam int D      = 16;
  localparam int N      = 2 * (ROWS + COLUMS);
  localparam int VW     = N * W;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mesh_noc_fabric_if #(.N(N), .W(W)) bus ();

  mesh_noc_fabric #(
    .ROWS(ROWS), .COLUMS(COLUMS), .pckg_sz(W), .fifo_depth(D), .bdcst(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // ---- reference model state ----
  logic [W-1:0] src_q [N][$];
  logic [W-1:0] in_q  [N][$];
  logic [W-1:0] out_q [N][$];
  logic [W-1:0] exp_q [$];
  int           last_gnt;
  logic [N-1:0] pop_v;
  bit           sb_en;
  int           sb_port;
  logic [N-1:0] obs_popin, obs_pndng;
  logic [VW-1:0] obs_data;
  int           n_cmp, n_err;
  int           popin0_cnt;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] term_addr(input int id);
    int r, c;
    if (id < COLUMS)                 begin r = 0;                  c = id + 1; end
    else if (id < COLUMS + ROWS)     begin r = id - COLUMS + 1;    c = 0; end
    else if (id < 2*COLUMS + ROWS)   begin r = ROWS + 1;           c = id - COLUMS - ROWS + 1; end
    else                             begin r = id - 2*COLUMS - ROWS + 1; c = COLUMS + 1; end
    return {4'(r), 4'(c)};
  endfunction

  function automatic logic [N-1:0] model_dest(input logic [W-1:0] p, input int src);
    logic [N-1:0] m;
    m = '0;
`ifdef MESH_BCAST_EN
    if (p[W-1 -: 8] == 8'hFF) begin
      m = '1;
      m[src] = 1'b0;
      return m;
    end
`endif
    for (int t = 0; t < N; t++)
      if (term_addr(t) == p[W-9 -: 8]) m[t] = 1'b1;
    return m;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    int sel;
    logic [7:0] nj, a;
    sel = $urandom_range(0, 9);
    nj  = (sel == 0) ? 8'hFF : 8'($urandom_range(0, 3));
    a   = (sel == 1) ? 8'($urandom) : term_addr($urandom_range(0, N-1));
    return {nj, a, 16'($urandom)};
  endfunction

  // ---- driver + model step: one clock edge ----
  task automatic step();
    logic [N-1:0]  exp_popin, exp_pndng, dm;
    logic [VW-1:0] exp_data;
    logic [W-1:0]  pkt;
    int g, idx;
    bit ok;
    for (int i = 0; i < N; i++) begin
      bus.pndng_i_in[i]       = (src_q[i].size() > 0);
      bus.data_out_i_in[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    bus.pop = pop_v;
    #1;
    for (int i = 0; i < N; i++)
      exp_popin[i] = (src_q[i].size() > 0) && (in_q[i].size() < D) && !reset;
    obs_popin = bus.popin;
    if (obs_popin[0]) popin0_cnt++;
    chk("popin", bus.popin, exp_popin);
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        in_q[i].delete();
        out_q[i].delete();
      end
      last_gnt = 0;
    end else begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (last_gnt + k) % N;
        if (g < 0 && in_q[idx].size() > 0) begin
          dm = model_dest(in_q[idx][0], idx);
          ok = 1'b1;
          for (int j = 0; j < N; j++)
            if (dm[j] && out_q[j].size() >= D && !pop_v[j]) ok = 1'b0;
          if (ok) g = idx;
        end
      end
      for (int j = 0; j < N; j++) begin
        if (pop_v[j] && out_q[j].size() > 0) begin
          pkt = out_q[j].pop_front();
          if (sb_en && j == sb_port && exp_q.size() > 0)
            chk("sb_order", bus.data_out[j*W +: W], exp_q.pop_front());
        end
      end
      if (g >= 0) begin
        pkt = in_q[g].pop_front();
        dm  = model_dest(pkt, g);
        for (int j = 0; j < N; j++)
          if (dm[j]) out_q[j].push_back(pkt);
        last_gnt = g;
      end
      for (int i = 0; i < N; i++)
        if (exp_popin[i]) in_q[i].push_back(src_q[i].pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    exp_data = '0;
    for (int j = 0; j < N; j++) begin
      exp_pndng[j] = !reset && (out_q[j].size() > 0);
      if (exp_pndng[j]) exp_data[j*W +: W] = out_q[j][0];
    end
    obs_pndng = bus.pndng;
    obs_data  = bus.data_out;
    chk("pndng", obs_pndng, exp_pndng);
    chk("data_out", obs_data, exp_data);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---- stimulus ----
  initial begin
    logic [N-1:0]  exp_p;
    logic [VW-1:0] exp_v;
    int            guard;
    n_cmp = 0; n_err = 0; last_gnt = 0; popin0_cnt = 0;
    sb_en = 1'b0; sb_port = 9; pop_v = '0;
    reset = 1'b1;
    bus.pndng_i_in = '0; bus.data_out_i_in = '0; bus.pop = '0;
    @(negedge clk);
    run(2);
    chk("reset_pndng", obs_pndng, '0);
    chk("reset_data", obs_data, '0);
    reset = 1'b0;

    // unicast 0 -> 9
    src_q[0].push_back(32'h0052_1234);
    step();
    chk("uc_popin", obs_popin, 16'h0001);
    step();
    chk("uc_popin_once", obs_popin, '0);
    chk("uc_pndng", obs_pndng, 16'h0200);
    chk("uc_data9", obs_data[9*W +: W], 32'h0052_1234);
    pop_v[9] = 1'b1;
    step();
    pop_v = '0;
    chk("uc_clear", obs_pndng, '0);

    // broadcast from 4
    src_q[4].push_back(32'hFF00_ABCD);
    run(2);
    exp_p = '0; exp_v = '0;
`ifdef MESH_BCAST_EN
    for (int j = 0; j < N; j++)
      if (j != 4) begin
        exp_p[j] = 1'b1;
        exp_v[j*W +: W] = 32'hFF00_ABCD;
      end
`endif
    chk("bc_pndng", obs_pndng, exp_p);
    chk("bc_data", obs_data, exp_v);
    pop_v = '1;
    step();
    pop_v = '0;

    // unmatched address is dropped
    src_q[3].push_back(32'h0000_0001);
    step();
    chk("inv_popin", obs_popin, 16'h0008);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("inv_pndng", obs_pndng, '0);
    end

    // backpressure: 40 packets 0 -> 9 with sink stalled
    popin0_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      src_q[0].push_back(32'h0052_0000 | k);
      exp_q.push_back(32'h0052_0000 | k);
    end
    run(40);
    chk("bp_accepted", popin0_cnt, 32);
    chk("bp_popin_low", obs_popin[0], 1'b0);
    chk("bp_out9", obs_pndng, 16'h0200);
    sb_en = 1'b1; pop_v[9] = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 150) begin step(); guard++; end
    chk("bp_drained", exp_q.size(), 0);
    step();

    // arbitration fairness from a clean pointer
    sb_en = 1'b0; pop_v = '0; reset = 1'b1;
    run(2);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src_q[1].push_back({8'h00, 8'h52, 8'd1, 8'(k)});
      src_q[2].push_back({8'h00, 8'h52, 8'd2, 8'(k)});
      exp_q.push_back({8'h00, 8'h52, 8'd1, 8'(k)});
      exp_q.push_back({8'h00, 8'h52, 8'd2, 8'(k)});
    end
    sb_en = 1'b1; pop_v[9] = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 60) begin step(); guard++; end
    chk("arb_drained", exp_q.size(), 0);
    sb_en = 1'b0; pop_v = '0;

    // reset while traffic is queued
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 3; k++)
        src_q[i].push_back({8'h00, term_addr($urandom_range(0, N-1)), 16'($urandom)});
    run(6);
    reset = 1'b1;
    step();
    chk("rst_pndng", obs_pndng, '0);
    chk("rst_data", obs_data, '0);
    chk("rst_popin", obs_popin, '0);
    reset = 1'b0;

    // random traffic with random sink pops
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0 && src_q[i].size() < 20) src_q[i].push_back(rand_pkt());
      pop_v = N'($urandom) | N'($urandom);
      step();
    end
    pop_v = '1;
    guard = 0;
    while (guard < 400) begin
      step();
      guard++;
    end
    chk("final_empty", obs_pndng, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mesh_noc_fabric.md
Name: mesh_noc_fabric

Overview:
- Packet-switched interconnect for a ROWS x COLUMS mesh. Terminals sit on the mesh periphery.
- Each terminal pulls packets from an external source FIFO, routes them by header address, and presents them on that terminal's output FIFO.
- Behavioural functional model of the router mesh, used as the DUT for the mesh verification environment.

Parameters:
- ROWS, 4, mesh rows (1..14).
- COLUMS, 4, mesh columns (1..14).
- pckg_sz, 32, packet width in bits (>=18).
- fifo_depth, 16, depth of each per-terminal input and output FIFO (power of 2, >=2).
- bdcst, 8'hFF, next-jump value that marks a broadcast packet.

Ports:
- clk, input, 1, single clock, all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- data_out_i_in, input, N*pckg_sz, source data per terminal; slice i is bits [i*pckg_sz +: pckg_sz]. N = 2*(ROWS+COLUMS).
- pndng_i_in, input, N, source terminal i has data available.
- popin, output, N, DUT consumes data_out_i_in slice i at this edge.
- data_out, output, N*pckg_sz, head of output FIFO i.
- pndng, output, N, output FIFO i non-empty.
- pop, input, N, sink removes head of output FIFO i.

Behaviour:
- Terminal numbering and addresses {row,col}, each 4 bits:
  - top: id c = 0..COLUMS-1, address {0, c+1}.
  - left: id COLUMS+r, address {r+1, 0}.
  - bottom: id COLUMS+ROWS+c, address {ROWS+1, c+1}.
  - right: id 2*COLUMS+ROWS+r, address {r+1, COLUMS+1}.
- Packet fields:
  - [pckg_sz-1 -: 8] nxt_jump.
  - [pckg_sz-9 -: 4] target row.
  - [pckg_sz-13 -: 4] target col.
  - [pckg_sz-17] mode (carried unchanged, no effect on delivery).
  - lower bits payload.
  - Packets are delivered bit-identical.
- Ingress:
  - popin[i] = pndng_i_in[i] & ~infifo_full[i] & ~reset (combinational).
  - When popin[i]=1, data_out_i_in slice i is written into input FIFO i at that edge.
- Switch:
  - Each cycle a round-robin arbiter scans input FIFO heads starting at the id after the last grant. It grants the first head whose destination(s) all have space.
  - Exactly one packet is moved per cycle.
  - The pointer does not advance if nothing is granted.
- Unicast: destination is the terminal whose address equals {row,col}. It may equal the source, in which case the packet is delivered back to the source terminal.
- Broadcast: nxt_jump==bdcst. The packet is written to all N-1 terminals except the source, in the same cycle, only if all of them have space; otherwise it waits.
- Unmatched address (e.g. {0,0} or row>ROWS+1): packet is popped from the input FIFO and discarded when granted.
- Egress:
  - pndng[i] = output FIFO i non-empty.
  - data_out slice i = head when non-empty, 0 when empty.
  - pop[i] with pndng[i]=1 removes the head at the edge.
  - pop on an empty FIFO is ignored.
  - An output FIFO accepts a push and a pop in the same cycle even when full.
- Latency: packet accepted at edge k, switched at edge k+1, pndng high after edge k+1. The minimum is 2 edges, source to visible output.
- Ordering: packets from one source to one destination are delivered in order.
- Backpressure: a full output FIFO stalls the head of any input FIFO targeting it (head-of-line blocking). Input FIFO full deasserts popin.
- Reset (synchronous, also mid-operation):
  - all FIFOs emptied, in-flight packets lost.
  - pndng=0, data_out=0, popin=0 while reset high.
  - arbiter pointer=0.

Optional Feature:
- Macro MESH_BCAST_EN.
- Defined: broadcast behaviour as above.
- Undefined: nxt_jump is ignored, and every packet is routed as unicast by {row,col}.

Test Plan:
- Unicast: defaults; terminal 0 presents 32'h00521234 for one pop. Required: popin[0] pulses once; after 2 edges pndng[9]=1 and data_out[9]=32'h00521234; pop[9] clears pndng[9]. No other pndng asserts.
- Broadcast (MESH_BCAST_EN): terminal 4 sends 32'hFF00_ABCD. Required: all 15 terminals except 4 show pndng=1 with 32'hFF00ABCD in the same cycle. Without the macro, the packet is dropped (address {0,0}).
- Invalid address: terminal 3 sends 32'h0000_0001. Required: popin[3] pulses; no pndng ever asserts.
- Backpressure: terminal 0 streams 40 packets to terminal 9, pop[9]=0. Required: 16 packets are in out FIFO 9 and 16 in in-FIFO 0, and popin[0] stays 0 afterwards. Then pop[9] continuously: all 40 packets are received in order.
- Arbitration: terminals 1 and 2 each send 4 packets to terminal 9 simultaneously. Required: out FIFO 9 receives them alternating 1,2,1,2,...
- Reset mid-stream: assert reset for 1 cycle with packets queued. Required: next cycle all pndng=0, data_out=0. Traffic resumes normally afterwards.
